// File: rtl/uart_rx_frame_check_if.sv
// Bit-strobe input and received-data output bundle between the RX sampler and the frame checker.
interface uart_rx_frame_check_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  bit_valid;
   logic                  sampled_bit;
   logic                  data_valid;
   logic [DATA_WIDTH-1:0] P_DATA;

   modport master (
      output bit_valid,
      output sampled_bit,
      input  data_valid,
      input  P_DATA
   );

   modport slave (
      input  bit_valid,
      input  sampled_bit,
      output data_valid,
      output P_DATA
   );
endinterface

// File: rtl/uart_rx_frame_check.sv
// UART RX frame checker: validates start, data, optional parity and one/two stop bits,
// keeping sticky error flags, saturating error counters and a one-cycle good-frame pulse.
module uart_rx_frame_check #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 8
) (
   input  logic                 clk,
   input  logic                 RST,
   input  logic                 chk_en,
   input  logic                 par_en,
   input  logic                 par_typ,
   input  logic                 stop_sel,
   input  logic                 rst_check,
   input  logic                 clr_cnt,
   uart_rx_frame_check_if.slave rx,
   output logic                 busy,
   output logic                 strt_glitch,
   output logic                 par_err,
   output logic                 stp_err,
   output logic [CNT_WIDTH-1:0] glitch_cnt,
   output logic [CNT_WIDTH-1:0] par_err_cnt,
   output logic [CNT_WIDTH-1:0] stp_err_cnt
);

   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {
      IDLE,
      DATA,
      PARITY,
      STOP1,
      STOP2
   } state_t;

   state_t                state;
   logic [DATA_WIDTH-1:0] shift_reg;
   logic [DATA_WIDTH-1:0] p_data;
   logic [BW-1:0]         bit_cnt;
   logic                  par_acc;
   logic                  cfg_par_en;
   logic                  cfg_par_typ;
   logic                  cfg_stop_sel;
   logic                  frame_par_bad;
   logic                  frame_stp_bad;
   logic                  valid_q;
   logic                  stop_bad_now;

   // A same-edge clear leaves a counter at 1 rather than 0 when it also increments.
   function automatic logic [CNT_WIDTH-1:0] bump(input logic [CNT_WIDTH-1:0] v, input logic clr);
      if (clr)
         return CNT_WIDTH'(1);
      return (&v) ? v : v + 1'b1;
   endfunction

   assign stop_bad_now  = frame_stp_bad | ~rx.sampled_bit;
   assign busy          = (state != IDLE);
   assign rx.P_DATA     = p_data;
   assign rx.data_valid = valid_q;

   always_ff @(posedge clk) begin
      if (!RST) begin
         state         <= IDLE;
         shift_reg     <= '0;
         p_data        <= '0;
         bit_cnt       <= '0;
         par_acc       <= 1'b0;
         cfg_par_en    <= 1'b0;
         cfg_par_typ   <= 1'b0;
         cfg_stop_sel  <= 1'b0;
         frame_par_bad <= 1'b0;
         frame_stp_bad <= 1'b0;
         valid_q       <= 1'b0;
         strt_glitch   <= 1'b0;
         par_err       <= 1'b0;
         stp_err       <= 1'b0;
         glitch_cnt    <= '0;
         par_err_cnt   <= '0;
         stp_err_cnt   <= '0;
      end else begin
         valid_q <= 1'b0;
         if (rst_check) begin
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
         end
         if (clr_cnt) begin
            glitch_cnt  <= '0;
            par_err_cnt <= '0;
            stp_err_cnt <= '0;
         end
         // Later assignments below let set events win over same-edge clears.
         if (!chk_en) begin
            state <= IDLE;
         end else if (rx.bit_valid) begin
            case (state)
               IDLE: begin
                  if (rx.sampled_bit) begin
                     strt_glitch <= 1'b1;
                     glitch_cnt  <= bump(glitch_cnt, clr_cnt);
                  end else begin
                     cfg_par_en    <= par_en;
                     cfg_par_typ   <= par_typ;
                     cfg_stop_sel  <= stop_sel;
                     bit_cnt       <= '0;
                     par_acc       <= 1'b0;
                     frame_par_bad <= 1'b0;
                     frame_stp_bad <= 1'b0;
                     state         <= DATA;
                  end
               end
               DATA: begin
                  shift_reg <= {rx.sampled_bit, shift_reg[DATA_WIDTH-1:1]};
                  par_acc   <= par_acc ^ rx.sampled_bit;
                  if (bit_cnt == LAST_BIT)
                     state <= cfg_par_en ? PARITY : STOP1;
                  else
                     bit_cnt <= bit_cnt + 1'b1;
               end
               PARITY: begin
                  if (rx.sampled_bit != (par_acc ^ cfg_par_typ)) begin
                     frame_par_bad <= 1'b1;
                     par_err       <= 1'b1;
                     par_err_cnt   <= bump(par_err_cnt, clr_cnt);
                  end
                  state <= STOP1;
               end
               STOP1, STOP2: begin
                  if (state == STOP1 && cfg_stop_sel) begin
                     if (!rx.sampled_bit)
                        frame_stp_bad <= 1'b1;
                     state <= STOP2;
                  end else begin
                     if (stop_bad_now) begin
                        stp_err     <= 1'b1;
                        stp_err_cnt <= bump(stp_err_cnt, clr_cnt);
                     end else if (!frame_par_bad) begin
                        p_data  <= shift_reg;
                        valid_q <= 1'b1;
                     end
                     state <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_frame_check.sv
// Scoreboard bench for uart_rx_frame_check: good frames queue expected data and arrival cycle,
// a negedge monitor pops on every data_valid; status flags and counters are checked directly.
module tb_uart_rx_frame_check;

   localparam int DW = 8;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          RST;
   logic          chk_en;
   logic          par_en;
   logic          par_typ;
   logic          stop_sel;
   logic          rst_check;
   logic          clr_cnt;
   logic          busy;
   logic          strt_glitch;
   logic          par_err;
   logic          stp_err;
   logic [CW-1:0] glitch_cnt;
   logic [CW-1:0] par_err_cnt;
   logic [CW-1:0] stp_err_cnt;

   int tests_run    = 0;
   int tests_failed = 0;
   int cyc          = 0;

   typedef struct {
      logic [DW-1:0] data;
      int            at_cyc;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;

   uart_rx_frame_check_if #(.DATA_WIDTH(DW)) rx();

   uart_rx_frame_check #(
      .DATA_WIDTH(DW),
      .CNT_WIDTH (CW)
   ) dut (
      .clk        (clk),
      .RST        (RST),
      .chk_en     (chk_en),
      .par_en     (par_en),
      .par_typ    (par_typ),
      .stop_sel   (stop_sel),
      .rst_check  (rst_check),
      .clr_cnt    (clr_cnt),
      .rx         (rx),
      .busy       (busy),
      .strt_glitch(strt_glitch),
      .par_err    (par_err),
      .stp_err    (stp_err),
      .glitch_cnt (glitch_cnt),
      .par_err_cnt(par_err_cnt),
      .stp_err_cnt(stp_err_cnt)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
      tests_run++;
      if (act !== req) begin
         tests_failed++;
         $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // Every data_valid cycle must match the oldest queued good frame, both in data and in timing.
   always @(negedge clk) begin
      if (rx.data_valid === 1'b1) begin
         if (sb_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("[TB] FAIL unexpected_data_valid: got pulse with P_DATA=0x%0h at cycle %0d, required no pulse",
                     rx.P_DATA, cyc);
         end else begin
            mon_e = sb_q.pop_front();
            check_output("frame_data", 32'(rx.P_DATA), 32'(mon_e.data));
            check_output("frame_latency_cycle", cyc, mon_e.at_cyc);
         end
      end
   end

   task automatic send_bit(input logic b);
      rx.bit_valid   = 1'b1;
      rx.sampled_bit = b;
      @(negedge clk);
      rx.bit_valid   = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_rst_check();
      rst_check = 1'b1;
      @(negedge clk);
      rst_check = 1'b0;
   endtask

   task automatic apply_stimulus(input logic [7:0] data, input logic has_par, input logic pbit,
                                 input logic s1, input logic s2, input logic two_stops,
                                 input logic good, input logic [7:0] exp_data);
      logic last_stop;
      send_bit(1'b0);
      for (int i = 0; i < DW; i++)
         send_bit(data[i]);
      if (has_par)
         send_bit(pbit);
      if (two_stops) begin
         send_bit(s1);
         last_stop = s2;
      end else begin
         last_stop = s1;
      end
      if (good)
         sb_q.push_back('{exp_data, cyc + 1});
      send_bit(last_stop);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got no end of stimulus, required completion before timeout");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      RST            = 1'b0;
      chk_en         = 1'b0;
      par_en         = 1'b0;
      par_typ        = 1'b0;
      stop_sel       = 1'b0;
      rst_check      = 1'b0;
      clr_cnt        = 1'b0;
      rx.bit_valid   = 1'b0;
      rx.sampled_bit = 1'b1;
      idle(2);
      check_output("reset_busy", 32'(busy), 0);
      check_output("reset_p_data", 32'(rx.P_DATA), 0);
      check_output("reset_data_valid", 32'(rx.data_valid), 0);
      check_output("reset_flags", {29'd0, strt_glitch, par_err, stp_err}, 0);
      check_output("reset_counts", {26'd0, glitch_cnt, par_err_cnt, stp_err_cnt}, 0);
      RST    = 1'b1;
      chk_en = 1'b1;
      idle(1);

      // 8N1 frame carrying 0xA5
      apply_stimulus(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'hA5);
      idle(2);
      check_output("t1_p_data", 32'(rx.P_DATA), 32'hA5);
      check_output("t1_busy", 32'(busy), 0);
      check_output("t1_flags", {29'd0, strt_glitch, par_err, stp_err}, 0);
      check_output("t1_counts", {26'd0, glitch_cnt, par_err_cnt, stp_err_cnt}, 0);

      // start glitch, then a good frame, then sticky clear
      send_bit(1'b1);
      check_output("t2_strt_glitch", 32'(strt_glitch), 1);
      check_output("t2_glitch_cnt", 32'(glitch_cnt), 1);
      check_output("t2_busy", 32'(busy), 0);
      apply_stimulus(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h3C);
      idle(1);
      check_output("t2_glitch_sticky", 32'(strt_glitch), 1);
      pulse_rst_check();
      check_output("t2_glitch_cleared", 32'(strt_glitch), 0);
      check_output("t2_glitch_cnt_kept", 32'(glitch_cnt), 1);

      // parity: 0x03 with parity bit 1 is bad for even, good for odd
      par_en  = 1'b1;
      par_typ = 1'b0;
      apply_stimulus(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00);
      idle(2);
      check_output("t3_par_err", 32'(par_err), 1);
      check_output("t3_par_err_cnt", 32'(par_err_cnt), 1);
      check_output("t3_p_data_held", 32'(rx.P_DATA), 32'h3C);
      par_typ = 1'b1;
      apply_stimulus(8'h03, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h03);
      idle(2);
      check_output("t3_p_data_odd", 32'(rx.P_DATA), 32'h03);
      check_output("t3_par_err_cnt_kept", 32'(par_err_cnt), 1);

      // two stop bits: one bad, then both bad counts once
      par_en   = 1'b0;
      stop_sel = 1'b1;
      apply_stimulus(8'h55, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(1);
      check_output("t4_stp_err", 32'(stp_err), 1);
      check_output("t4_stp_err_cnt_1", 32'(stp_err_cnt), 1);
      apply_stimulus(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
      idle(1);
      check_output("t4_stp_err_cnt_2", 32'(stp_err_cnt), 2);
      check_output("t4_p_data_held", 32'(rx.P_DATA), 32'h03);

      // config toggled right after the start bit must not affect the frame in progress
      stop_sel = 1'b1;
      par_en   = 1'b0;
      send_bit(1'b0);
      stop_sel = 1'b0;
      par_en   = 1'b1;
      for (int i = 0; i < DW; i++)
         send_bit(i == 0 || i == 7);
      send_bit(1'b1);
      sb_q.push_back('{8'h81, cyc + 1});
      send_bit(1'b1);
      idle(1);
      par_en = 1'b0;
      check_output("t4_toggle_glitch_cnt", 32'(glitch_cnt), 1);
      check_output("t4_toggle_stp_err_cnt", 32'(stp_err_cnt), 2);
      check_output("t4_toggle_par_err_cnt", 32'(par_err_cnt), 1);
      check_output("t4_toggle_busy", 32'(busy), 0);

      // counter clear, saturation, and same-edge clear/set priority
      clr_cnt = 1'b1;
      idle(1);
      clr_cnt = 1'b0;
      check_output("t5_counts_cleared", {26'd0, glitch_cnt, par_err_cnt, stp_err_cnt}, 0);
      for (int i = 0; i < 5; i++)
         send_bit(1'b1);
      check_output("t5_glitch_saturated", 32'(glitch_cnt), 3);
      clr_cnt = 1'b1;
      send_bit(1'b1);
      clr_cnt = 1'b0;
      check_output("t5_clr_with_glitch", 32'(glitch_cnt), 1);
      rst_check = 1'b1;
      send_bit(1'b1);
      rst_check = 1'b0;
      check_output("t5_rst_check_with_glitch", 32'(strt_glitch), 1);
      check_output("t5_rst_check_other_flags", {30'd0, par_err, stp_err}, 0);
      check_output("t5_glitch_cnt_2", 32'(glitch_cnt), 2);

      // reset in the middle of a frame
      send_bit(1'b0);
      for (int i = 0; i < 4; i++)
         send_bit(i[0] == 1'b0);
      check_output("t6_busy_mid_frame", 32'(busy), 1);
      RST = 1'b0;
      idle(1);
      check_output("t6_reset_busy", 32'(busy), 0);
      check_output("t6_reset_p_data", 32'(rx.P_DATA), 0);
      check_output("t6_reset_flags", {29'd0, strt_glitch, par_err, stp_err}, 0);
      check_output("t6_reset_counts", {26'd0, glitch_cnt, par_err_cnt, stp_err_cnt}, 0);
      RST = 1'b1;
      idle(1);

      // chk_en dropped on the parity strobe aborts the frame silently
      par_en   = 1'b1;
      par_typ  = 1'b0;
      stop_sel = 1'b0;
      send_bit(1'b0);
      for (int i = 0; i < DW; i++)
         send_bit(i < 4);
      chk_en = 1'b0;
      send_bit(1'b1);
      chk_en = 1'b1;
      check_output("t6_abort_busy", 32'(busy), 0);
      check_output("t6_abort_par_err", 32'(par_err), 0);
      check_output("t6_abort_counts", {26'd0, glitch_cnt, par_err_cnt, stp_err_cnt}, 0);
      apply_stimulus(8'h5A, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A);
      idle(2);
      check_output("t6_next_frame_p_data", 32'(rx.P_DATA), 32'h5A);
      check_output("t6_next_frame_counts", {26'd0, glitch_cnt, par_err_cnt, stp_err_cnt}, 0);

      idle(3);
      check_output("scoreboard_drained", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/uart_rx_frame_check.md
Name: uart_rx_frame_check

Overview:
Parametrised successor to the single start-bit checker in the UART RX path. It validates a whole received frame: start bit, LSB-first data shift-in, optional even/odd parity, and one or two stop bits. It produces sticky per-type error flags, saturating per-type error counters and a one-cycle data_valid pulse. It sits after the RX oversampling/majority sampler, which supplies one strobe per decided bit, and before the RX data register / SYS_CTRL.

Parameters:
DATA_WIDTH, 8, number of data bits per frame (5..9 supported)
CNT_WIDTH, 8, width of each saturating error counter

Ports:
clk  input  1  block clock
RST  input  1  reset; synchronous and active-low
chk_en  input  1  block enable; low aborts any frame in progress
bit_valid  input  1  one-cycle strobe: sampled_bit holds a decided bit. The first strobe of a frame is the start-bit mid-sample.
sampled_bit  input  1  decided bit value
par_en  input  1  parity bit present
par_typ  input  1  0 = even, 1 = odd
stop_sel  input  1  0 = one stop bit, 1 = two stop bits
rst_check  input  1  clear sticky flags
clr_cnt  input  1  clear all error counters
busy  output  1  frame in progress (FSM not IDLE)
P_DATA  output  DATA_WIDTH  last good frame's data
data_valid  output  1  one-cycle pulse, good frame
strt_glitch  output  1  sticky start-glitch flag
par_err  output  1  sticky parity-error flag
stp_err  output  1  sticky stop-error flag
glitch_cnt  output  CNT_WIDTH  start glitches seen
par_err_cnt  output  CNT_WIDTH  parity errors seen
stp_err_cnt  output  CNT_WIDTH  frames with a stop error

Behaviour:
- Reset, RST=0 sampled at a clk edge: FSM=IDLE. All outputs 0, including P_DATA and all counters. Internal shift register, bit counter and per-frame flags are cleared. RST has priority over every other input.
- All state changes occur only on clk edges where chk_en=1 and bit_valid=1, except the actions listed below.
- FSM states:
  - IDLE
    - Strobe with sampled_bit=1: start glitch. Set strt_glitch, increment glitch_cnt, stay in IDLE.
    - Strobe with sampled_bit=0: latch par_en, par_typ and stop_sel into frame config; clear per-frame flags and bit counter; go to DATA. Config inputs changing mid-frame have no effect.
  - DATA
    - Shift sampled_bit in LSB-first and fold it into running parity.
    - After the DATA_WIDTH-th strobe, go to PARITY if latched par_en=1, else STOP1.
  - PARITY
    - Expected bit = XOR(data) XOR par_typ.
    - On mismatch, set the per-frame parity-bad flag, set par_err, and increment par_err_cnt.
    - Go to STOP1.
  - STOP1
    - sampled_bit=0: set per-frame stop-bad flag.
    - Go to STOP2 if latched stop_sel=1, else finish.
  - STOP2
    - sampled_bit=0: set per-frame stop-bad flag.
    - Finish.
- Finish (evaluated on the final stop strobe edge):
  - If the per-frame stop-bad flag is set: set stp_err and increment stp_err_cnt by exactly 1 per frame, even if both stop bits are bad.
  - If neither per-frame bad flag is set: load P_DATA and pulse data_valid high for exactly the next cycle. Latency is 1 clk from the final stop strobe.
  - Return to IDLE. A strobe in the cycle immediately after finish is handled by IDLE.
- Failed frames: P_DATA holds its old value; data_valid stays 0.
- busy is 1 in every state except IDLE.
- chk_en=0 in any state: FSM returns to IDLE on that edge. The partial frame is discarded with no flags, no counts and no data_valid. Flags, counters and P_DATA are retained.
- Sticky flags: rst_check=1 clears all three. If a set event occurs on the same edge, set wins.
- Counters:
  - Each saturates at 2^CNT_WIDTH-1.
  - clr_cnt=1 clears all counters. If an increment occurs on the same edge, that counter becomes 1.
- Strobes on back-to-back cycles are legal. No minimum spacing between strobes.

Test Plan:
1. 8N1 frame, bits 0,1,0,1,0,0,1,0,1 then stop 1 -> data_valid pulses for 1 cycle exactly 1 clk after the stop strobe; P_DATA=0xA5; all flags and counters 0; busy 0 afterwards.
2. First strobe sampled_bit=1 -> strt_glitch=1, glitch_cnt=1, busy stays 0. A following good 0x3C frame is received correctly and strt_glitch remains 1. Then rst_check pulse -> strt_glitch=0.
3. Even parity, data 0x03, parity bit 1 -> par_err=1, par_err_cnt=1, no data_valid, P_DATA unchanged (0x3C). Same frame with odd parity (par_typ=1) -> data_valid pulses and P_DATA=0x03.
4. stop_sel=1, stop bits 1,0 -> stp_err=1, stp_err_cnt=1. Both stop bits 0 -> stp_err_cnt=2, not 3. Toggling stop_sel mid-frame has no effect on the frame in progress.
5. CNT_WIDTH=2 with 5 start glitches -> glitch_cnt=3 (saturated). clr_cnt on the same edge as a glitch -> glitch_cnt=1. rst_check on the same edge as a glitch -> strt_glitch=1.
6. RST=0 after the 4th data strobe -> next edge shows all outputs 0 and busy 0. Separately, chk_en=0 during PARITY -> IDLE, counts unchanged, no data_valid; the next frame decodes correctly.
